// File: rtl/carfield_pkg.sv
// Shared types and defaults for the Carfield power-domain isolation sequencer.
// The optional drain timeout is enabled by defining CARFIELD_ISO_TIMEOUT_EN.
package carfield_pkg;

  typedef enum logic [2:0] {
    ISO_RUN      = 3'd0,
    ISO_DRAIN    = 3'd1,
    ISO_ISOLATE  = 3'd2,
    ISO_OFF      = 3'd3,
    ISO_WAKE_REQ = 3'd4,
    ISO_WAKE     = 3'd5,
    ISO_RELEASE  = 3'd6
  } carfield_iso_state_e;

  // Domain indices follow the external AXI master indices.
  localparam int unsigned CarfieldSafetyIdx     = 32'd0;
  localparam int unsigned CarfieldSecurityIdx   = 32'd1;
  localparam int unsigned CarfieldFpClusterIdx  = 32'd2;
  localparam int unsigned CarfieldIntClusterIdx = 32'd3;

  localparam int unsigned CarfieldNumDomains     = 32'd4;
  localparam int unsigned CarfieldDrainTimeout   = 32'd1024;
  localparam int unsigned CarfieldIsoSetupCycles = 32'd2;
  localparam int unsigned CarfieldRstCycles      = 32'd16;

  typedef struct packed {
    logic gate;
    logic iso;
    logic clk_en;
    logic rst_n;
    logic ack;
  } carfield_iso_out_t;

  function automatic carfield_iso_out_t iso_state_outputs(input carfield_iso_state_e state);
    carfield_iso_out_t o;
    case (state)
      ISO_RUN:      o = '{gate: 1'b0, iso: 1'b0, clk_en: 1'b1, rst_n: 1'b1, ack: 1'b0};
      ISO_DRAIN:    o = '{gate: 1'b1, iso: 1'b0, clk_en: 1'b1, rst_n: 1'b1, ack: 1'b0};
      ISO_ISOLATE:  o = '{gate: 1'b1, iso: 1'b1, clk_en: 1'b1, rst_n: 1'b1, ack: 1'b0};
      ISO_OFF:      o = '{gate: 1'b1, iso: 1'b1, clk_en: 1'b0, rst_n: 1'b0, ack: 1'b1};
      ISO_WAKE_REQ: o = '{gate: 1'b1, iso: 1'b1, clk_en: 1'b0, rst_n: 1'b0, ack: 1'b0};
      ISO_WAKE:     o = '{gate: 1'b1, iso: 1'b1, clk_en: 1'b1, rst_n: 1'b0, ack: 1'b0};
      ISO_RELEASE:  o = '{gate: 1'b1, iso: 1'b0, clk_en: 1'b1, rst_n: 1'b1, ack: 1'b0};
      default:      o = '{gate: 1'b0, iso: 1'b0, clk_en: 1'b1, rst_n: 1'b1, ack: 1'b0};
    endcase
    return o;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/carfield_domain_fsm.sv
// One domain's isolate/wake sequencer with its shared phase counter.
// Drain timeout logic exists only when CARFIELD_ISO_TIMEOUT_EN is defined.
module carfield_domain_fsm
  import carfield_pkg::*;
#(
`ifdef CARFIELD_ISO_TIMEOUT_EN
  parameter int unsigned DrainTimeout   = CarfieldDrainTimeout,
`endif
  parameter int unsigned IsoSetupCycles = CarfieldIsoSetupCycles,
  parameter int unsigned RstCycles      = CarfieldRstCycles
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic iso_req_i,
  input  logic axi_busy_i,
  input  logic grant_i,
  output logic gate_o,
  output logic iso_o,
  output logic clk_en_o,
  output logic rst_no,
  output logic ack_o,
  output logic timeout_o,
  output logic wake_req_o,
  output logic release_o
);

`ifdef CARFIELD_ISO_TIMEOUT_EN
  localparam int unsigned CntMax = max_u(DrainTimeout, max_u(IsoSetupCycles, RstCycles));
`else
  localparam int unsigned CntMax = max_u(IsoSetupCycles, RstCycles);
`endif
  localparam int unsigned CntW = $clog2(CntMax + 32'd1);
  localparam logic [CntW-1:0] CntSat  = CntW'(CntMax);
  localparam logic [CntW-1:0] IsoLast = CntW'(IsoSetupCycles - 32'd1);
  localparam logic [CntW-1:0] RstLast = CntW'(RstCycles - 32'd1);
`ifdef CARFIELD_ISO_TIMEOUT_EN
  localparam logic [CntW-1:0] DrainLast = CntW'(DrainTimeout);
`endif

  carfield_iso_state_e state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  carfield_iso_out_t   out_q, out_d;
`ifdef CARFIELD_ISO_TIMEOUT_EN
  logic                timeout_q, timeout_d;
`endif

  // Next-state logic; abort beats drain completion, cancel beats nothing once granted.
  always_comb begin
    state_d = state_q;
`ifdef CARFIELD_ISO_TIMEOUT_EN
    timeout_d = timeout_q;
`endif
    case (state_q)
      ISO_RUN: begin
        if (iso_req_i) begin
          state_d = ISO_DRAIN;
`ifdef CARFIELD_ISO_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end else begin
          state_d = ISO_RUN;
        end
      end
      ISO_DRAIN: begin
        if (!iso_req_i) begin
          state_d = ISO_RUN;
        end else if (!axi_busy_i) begin
          state_d = ISO_ISOLATE;
`ifdef CARFIELD_ISO_TIMEOUT_EN
        end else if (cnt_q == DrainLast) begin
          state_d   = ISO_ISOLATE;
          timeout_d = 1'b1;
`endif
        end else begin
          state_d = ISO_DRAIN;
        end
      end
      ISO_ISOLATE: begin
        if (cnt_q == IsoLast) state_d = ISO_OFF;
        else                  state_d = ISO_ISOLATE;
      end
      ISO_OFF: begin
        if (!iso_req_i) state_d = ISO_WAKE_REQ;
        else            state_d = ISO_OFF;
      end
      ISO_WAKE_REQ: begin
        if (grant_i)        state_d = ISO_WAKE;
        else if (iso_req_i) state_d = ISO_OFF;
        else                state_d = ISO_WAKE_REQ;
      end
      ISO_WAKE: begin
        if (cnt_q == RstLast) state_d = ISO_RELEASE;
        else                  state_d = ISO_WAKE;
      end
      ISO_RELEASE: state_d = ISO_RUN;
      default:     state_d = ISO_RUN;
    endcase
  end

  // Phase counter restarts on every state change and saturates otherwise.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != CntSat) begin
      cnt_d = cnt_q + CntW'(1);
    end else begin
      cnt_d = cnt_q;
    end
    out_d = iso_state_outputs(state_d);
  end

  // State, counter and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ISO_RUN;
      cnt_q   <= '0;
      out_q   <= iso_state_outputs(ISO_RUN);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

`ifdef CARFIELD_ISO_TIMEOUT_EN
  // Sticky timeout flag, cleared only when a new isolation starts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) timeout_q <= 1'b0;
    else         timeout_q <= timeout_d;
  end
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign gate_o     = out_q.gate;
  assign iso_o      = out_q.iso;
  assign clk_en_o   = out_q.clk_en;
  assign rst_no     = out_q.rst_n;
  assign ack_o      = out_q.ack;
  assign wake_req_o = (state_q == ISO_WAKE_REQ);
  assign release_o  = (state_q == ISO_RELEASE);

endmodule

// File: rtl/carfield_domain_iso_ctrl.sv
// Per-domain isolation sequencers plus the single-slot round-robin wake scheduler.
// Define CARFIELD_ISO_TIMEOUT_EN to enable the drain timeout and timeout_o.
module carfield_domain_iso_ctrl
  import carfield_pkg::*;
#(
  parameter int unsigned NumDomains     = CarfieldNumDomains,
  parameter int unsigned DrainTimeout   = CarfieldDrainTimeout,
  parameter int unsigned IsoSetupCycles = CarfieldIsoSetupCycles,
  parameter int unsigned RstCycles      = CarfieldRstCycles
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NumDomains-1:0] iso_req_i,
  input  logic [NumDomains-1:0] axi_busy_i,
  output logic [NumDomains-1:0] gate_o,
  output logic [NumDomains-1:0] iso_o,
  output logic [NumDomains-1:0] clk_en_o,
  output logic [NumDomains-1:0] rst_no,
  output logic [NumDomains-1:0] ack_o,
  output logic [NumDomains-1:0] timeout_o,
  output logic                  wake_busy_o
);

  localparam int unsigned PtrW = (NumDomains > 32'd1) ? $clog2(NumDomains) : 32'd1;

  if ((NumDomains < 32'd1) || (DrainTimeout < 32'd1) ||
      (IsoSetupCycles < 32'd1) || (RstCycles < 32'd1)) begin : g_param_check
    $error("carfield_domain_iso_ctrl: all parameters must be at least 1");
  end

  logic [NumDomains-1:0] wake_req_s;
  logic [NumDomains-1:0] release_s;
  logic [NumDomains-1:0] cand_s;
  logic [NumDomains-1:0] grant_s;
  logic [PtrW-1:0]       idx_s;
  logic                  found_s;
  logic [PtrW-1:0]       ptr_q, ptr_d;
  logic                  wake_busy_q, wake_busy_d;

  for (genvar i = 0; i < NumDomains; i++) begin : g_dom
    carfield_domain_fsm #(
`ifdef CARFIELD_ISO_TIMEOUT_EN
      .DrainTimeout   (DrainTimeout),
`endif
      .IsoSetupCycles (IsoSetupCycles),
      .RstCycles      (RstCycles)
    ) u_fsm (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .iso_req_i  (iso_req_i[i]),
      .axi_busy_i (axi_busy_i[i]),
      .grant_i    (grant_s[i]),
      .gate_o     (gate_o[i]),
      .iso_o      (iso_o[i]),
      .clk_en_o   (clk_en_o[i]),
      .rst_no     (rst_no[i]),
      .ack_o      (ack_o[i]),
      .timeout_o  (timeout_o[i]),
      .wake_req_o (wake_req_s[i]),
      .release_o  (release_s[i])
    );
  end

  // A requester re-raising iso_req is cancelling, so it is not eligible for the slot.
  assign cand_s = wake_req_s & ~iso_req_i;

  // Round-robin search starting at the pointer; only while the slot is free.
  always_comb begin
    grant_s = '0;
    ptr_d   = ptr_q;
    found_s = 1'b0;
    idx_s   = ptr_q;
    if (!wake_busy_q) begin
      for (int k = 0; k < NumDomains; k++) begin
        if (!found_s && cand_s[idx_s]) begin
          found_s        = 1'b1;
          grant_s[idx_s] = 1'b1;
          ptr_d          = (idx_s == PtrW'(NumDomains - 32'd1)) ? '0 : (idx_s + PtrW'(1));
        end else begin
          found_s = found_s;
        end
        idx_s = (idx_s == PtrW'(NumDomains - 32'd1)) ? '0 : (idx_s + PtrW'(1));
      end
    end else begin
      grant_s = '0;
    end
  end

  // Slot occupancy: taken on grant, freed as the holder enters RUN.
  always_comb begin
    wake_busy_d = wake_busy_q;
    if (|grant_s) begin
      wake_busy_d = 1'b1;
    end else if (|release_s) begin
      wake_busy_d = 1'b0;
    end else begin
      wake_busy_d = wake_busy_q;
    end
  end

  // Scheduler registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q       <= '0;
      wake_busy_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      wake_busy_q <= wake_busy_d;
    end
  end

  assign wake_busy_o = wake_busy_q;

endmodule

// File: tb/tb_carfield_domain_iso_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a timeline model.
module tb_carfield_domain_iso_ctrl;

  localparam int N  = 4;
  localparam int DT = 64;
  localparam int IS = 2;
  localparam int RC = 16;
`ifdef CARFIELD_ISO_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int M_ON = 0, M_DRN = 1, M_ISO = 2, M_OFF = 3, M_WREQ = 4, M_WAKE = 5, M_REL = 6;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic [3:0] iso_req = 4'h0;
  logic [3:0] busy = 4'h0;
  logic [3:0] gate, iso, clk_en, rst_n, ack, tmo;
  logic wake_busy;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  int m_mode[N];
  int m_rem[N];
  bit m_to[N];
  int m_owner;
  int m_start;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  carfield_domain_iso_ctrl #(
    .NumDomains(N), .DrainTimeout(DT), .IsoSetupCycles(IS), .RstCycles(RC)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .iso_req_i(iso_req), .axi_busy_i(busy),
    .gate_o(gate), .iso_o(iso), .clk_en_o(clk_en), .rst_no(rst_n),
    .ack_o(ack), .timeout_o(tmo), .wake_busy_o(wake_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_mode[i] = M_ON;
      m_rem[i]  = 0;
      m_to[i]   = 1'b0;
    end
    m_owner = -1;
    m_start = 0;
  endtask

  task automatic model_step();
    int g;
    bit freed;
    g = -1;
    freed = 1'b0;
    if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_start + k) % N;
        if (g < 0 && m_mode[j] == M_WREQ && !iso_req[j]) g = j;
      end
    end
    for (int i = 0; i < N; i++) begin
      case (m_mode[i])
        M_ON:  if (iso_req[i]) begin m_mode[i] = M_DRN; m_rem[i] = DT + 1; m_to[i] = 1'b0; end
        M_DRN: begin
          if (!iso_req[i]) m_mode[i] = M_ON;
          else if (!busy[i]) begin m_mode[i] = M_ISO; m_rem[i] = IS; end
          else if (TO_EN) begin
            m_rem[i]--;
            if (m_rem[i] == 0) begin m_mode[i] = M_ISO; m_rem[i] = IS; m_to[i] = 1'b1; end
          end
        end
        M_ISO: begin m_rem[i]--; if (m_rem[i] == 0) m_mode[i] = M_OFF; end
        M_OFF: if (!iso_req[i]) m_mode[i] = M_WREQ;
        M_WREQ: begin
          if (i == g) begin m_mode[i] = M_WAKE; m_rem[i] = RC; end
          else if (iso_req[i]) m_mode[i] = M_OFF;
        end
        M_WAKE: begin m_rem[i]--; if (m_rem[i] == 0) m_mode[i] = M_REL; end
        M_REL: begin m_mode[i] = M_ON; freed = 1'b1; end
        default: m_mode[i] = M_ON;
      endcase
    end
    if (g >= 0) begin
      m_owner = g;
      m_start = (g + 1) % N;
    end else if (freed) begin
      m_owner = -1;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_ni);
      if (!rst_ni) model_reset();
      else model_step();
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      logic [3:0] e_gate, e_iso, e_clk, e_rst, e_ack, e_to;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        e_gate[i] = (m_mode[i] != M_ON);
        e_iso[i]  = (m_mode[i] inside {M_ISO, M_OFF, M_WREQ, M_WAKE});
        e_clk[i]  = !(m_mode[i] inside {M_OFF, M_WREQ});
        e_rst[i]  = !(m_mode[i] inside {M_OFF, M_WREQ, M_WAKE});
        e_ack[i]  = (m_mode[i] == M_OFF);
        e_to[i]   = m_to[i];
      end
      chk("gate", 32'(gate), 32'(e_gate));
      chk("iso", 32'(iso), 32'(e_iso));
      chk("clk_en", 32'(clk_en), 32'(e_clk));
      chk("rst_n", 32'(rst_n), 32'(e_rst));
      chk("ack", 32'(ack), 32'(e_ack));
      chk("timeout", 32'(tmo), 32'(e_to));
      chk("wake_busy", 32'(wake_busy), 32'(m_owner >= 0));
      chk("one_waking", 32'($countones(clk_en & ~rst_n) <= 1), 32'd1);
    end
  end

  initial begin
    #1000000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ack(input logic [3:0] mask, input int budget, input string nm);
    int k;
    k = 0;
    while (((ack & mask) !== mask) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(nm, 32'(ack & mask), 32'(mask));
  endtask

  task automatic random_phase(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 23) == 0) iso_req[i] = ~iso_req[i];
        if ($urandom_range(0, 7) == 0) busy[i] = ($urandom_range(0, 2) != 0);
      end
    end
  endtask

  initial begin
    int ce[N];
    int rs[N];
    int d;
    bit seen;

    tick(3);
    #2 rst_ni = 1'b1;
    tick(1);
    chk("reset_gate", 32'(gate), 32'h0);
    chk("reset_clk_en", 32'(clk_en), 32'hF);
    chk("reset_rst_n", 32'(rst_n), 32'hF);
    chk("reset_ack", 32'(ack), 32'h0);
    chk("reset_wake_busy", 32'(wake_busy), 32'h0);

    // Clean isolate of domain 0.
    iso_req[0] = 1'b1;
    tick(1);
    chk("clean_gate_t1", 32'(gate[0]), 32'd1);
    chk("clean_iso_t1", 32'(iso[0]), 32'd0);
    tick(1);
    chk("clean_iso_t2", 32'(iso[0]), 32'd1);
    chk("clean_clk_en_t2", 32'(clk_en[0]), 32'd1);
    tick(1);
    chk("clean_ack_t3", 32'(ack[0]), 32'd0);
    tick(1);
    chk("clean_clk_en_t4", 32'(clk_en[0]), 32'd0);
    chk("clean_rst_n_t4", 32'(rst_n[0]), 32'd0);
    chk("clean_ack_t4", 32'(ack[0]), 32'd1);
    chk("clean_others", 32'(gate[3:1]), 32'd0);

    // Drain wait on domain 1.
    busy[1] = 1'b1;
    iso_req[1] = 1'b1;
    tick(50);
    chk("drain_iso_before", 32'(iso[1]), 32'd0);
    busy[1] = 1'b0;
    tick(1);
    chk("drain_iso_after", 32'(iso[1]), 32'd1);
    chk("drain_no_timeout", 32'(tmo[1]), 32'd0);
    wait_ack(4'b0011, 20, "drain_off");

    // Stuck-busy drain on domain 2.
    busy[2] = 1'b1;
    iso_req[2] = 1'b1;
    tick(1);
    chk("to_gate", 32'(gate[2]), 32'd1);
`ifdef CARFIELD_ISO_TIMEOUT_EN
    tick(DT);
    chk("to_iso_early", 32'(iso[2]), 32'd0);
    tick(1);
    chk("to_iso", 32'(iso[2]), 32'd1);
    chk("to_flag", 32'(tmo[2]), 32'd1);
`else
    tick(DT + 40);
    chk("noto_iso", 32'(iso[2]), 32'd0);
    chk("noto_flag", 32'(tmo[2]), 32'd0);
`endif
    busy[2] = 1'b0;
    iso_req[3] = 1'b1;
    wait_ack(4'b1111, 40, "all_off");

    // Serialized wake of all four domains.
    for (int i = 0; i < N; i++) begin ce[i] = -1; rs[i] = -1; end
    iso_req = 4'h0;
    d = cyc;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (clk_en[i] && ce[i] < 0) ce[i] = cyc;
        if (rst_n[i] && rs[i] < 0) rs[i] = cyc;
      end
    end
    chk("wake_first_latency", 32'(ce[0] - d), 32'd2);
    for (int i = 0; i < N; i++) chk($sformatf("wake_rst_delay_%0d", i), 32'(rs[i] - ce[i]), 32'(RC));
    for (int i = 1; i < N; i++) chk($sformatf("wake_spacing_%0d", i), 32'(ce[i] - ce[i-1]), 32'(RC + 2));
    chk("wake_all_run", 32'(gate), 32'h0);
    chk("timeout_held", 32'(tmo[2]), 32'(TO_EN));

    // Next isolation clears the sticky timeout.
    iso_req[2] = 1'b1;
    tick(1);
    chk("timeout_cleared", 32'(tmo[2]), 32'd0);
    wait_ack(4'b0100, 20, "d2_off");

    // Abort during DRAIN.
    busy[0] = 1'b1;
    iso_req[0] = 1'b1;
    tick(1);
    chk("abort_gate", 32'(gate[0]), 32'd1);
    chk("abort_iso_a", 32'(iso[0]), 32'd0);
    iso_req[0] = 1'b0;
    tick(1);
    chk("abort_run", 32'(gate[0]), 32'd0);
    chk("abort_iso_b", 32'(iso[0]), 32'd0);
    busy[0] = 1'b0;

    // Cancel in WAKE_REQ while domain 2 holds the slot.
    iso_req[1] = 1'b1;
    wait_ack(4'b0110, 20, "cancel_setup");
    iso_req[2] = 1'b0;
    tick(3);
    chk("cancel_d2_waking", 32'(clk_en[2]), 32'd1);
    iso_req[1] = 1'b0;
    tick(2);
    chk("cancel_wreq_ack", 32'(ack[1]), 32'd0);
    iso_req[1] = 1'b1;
    tick(2);
    chk("cancel_off_ack", 32'(ack[1]), 32'd1);
    seen = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (clk_en[1]) seen = 1'b1;
    end
    chk("cancel_no_grant", 32'(seen), 32'd0);

    random_phase(2500);

    // Reset while a domain is in WAKE.
    iso_req = 4'hF;
    busy = 4'h0;
    wait_ack(4'b1111, 200, "pre_reset_off");
    iso_req = 4'h0;
    tick(5);
    chk("pre_reset_wake_busy", 32'(wake_busy), 32'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_gate", 32'(gate), 32'h0);
    chk("rst_iso", 32'(iso), 32'h0);
    chk("rst_clk_en", 32'(clk_en), 32'hF);
    chk("rst_rst_n", 32'(rst_n), 32'hF);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_timeout", 32'(tmo), 32'h0);
    chk("rst_wake_busy", 32'(wake_busy), 32'h0);
    @(negedge clk);
    #2 rst_ni = 1'b1;

    random_phase(800);
    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
